// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master among NREQ clients.
// Latches the winner's operands, drives go, retries NACKs, aborts on timeout.
module i2c_req_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic              ok,
    output logic              busy,
    output logic              i2c_go,
    output logic [6:0]        i2c_addr,
    output logic [7:0]        i2c_data,
    input  logic              i2c_done,
    input  logic              i2c_success
);

    localparam int unsigned   IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned   RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [15:0]   TMO_LIM   = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        GAP,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [NREQ-1:0] grant_d, ack_d;
    logic            ok_d, busy_d, go_d;
    logic [6:0]      addr_d;
    logic [7:0]      data_d;

    logic [6:0]      addr_vec [NREQ];
    logic [7:0]      data_vec [NREQ];
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_vec[i] = req_addr[7*i +: 7];
            data_vec[i] = req_data[8*i +: 8];
        end
    end

    // First requester at or after ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        int unsigned   cand;
        logic [IW-1:0] cand_idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = cand[IW-1:0];
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        retry_d = retry_q;
        tmo_d   = tmo_q;
        grant_d = grant;
        ack_d   = '0;
        ok_d    = 1'b0;
        addr_d  = i2c_addr;
        data_d  = i2c_data;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d           = pick_idx;
                    addr_d            = addr_vec[pick_idx];
                    data_d            = data_vec[pick_idx];
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    retry_d           = '0;
                    tmo_d             = '0;
                    state_d           = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // done takes priority over a coincident timeout
                if (i2c_done) begin
                    if (i2c_success) begin
                        ack_d   = grant;
                        ok_d    = 1'b1;
                        state_d = RESP;
                    end else if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + RW'(1);
                        state_d = GAP;
                    end else begin
                        ack_d   = grant;
                        state_d = RESP;
                    end
                end else if (tmo_q >= TMO_LIM) begin
                    ack_d   = grant;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            GAP: begin
                tmo_d   = '0;
                state_d = LAUNCH;
            end
            RESP: begin
                ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        go_d   = (state_d == LAUNCH) || (state_d == WAIT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            retry_q  <= '0;
            tmo_q    <= '0;
            grant    <= '0;
            ack      <= '0;
            ok       <= 1'b0;
            busy     <= 1'b0;
            i2c_go   <= 1'b0;
            i2c_addr <= '0;
            i2c_data <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            retry_q  <= retry_d;
            tmo_q    <= tmo_d;
            grant    <= grant_d;
            ack      <= ack_d;
            ok       <= ok_d;
            busy     <= busy_d;
            i2c_go   <= go_d;
            i2c_addr <= addr_d;
            i2c_data <= data_d;
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed self-checking bench for i2c_req_arbiter (NREQ=4, MAX_RETRY=2, TIMEOUT=20).
module tb_i2c_req_arbiter;

    logic        mclk;
    logic        rst;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        ok;
    logic        busy;
    logic        i2c_go;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_data;
    logic        i2c_done;
    logic        i2c_success;

    int vectors;
    int miscompares;

    i2c_req_arbiter #(
        .NREQ(4),
        .MAX_RETRY(2),
        .TIMEOUT(20)
    ) dut (
        .mclk(mclk),
        .rst(rst),
        .req(req),
        .req_addr(req_addr),
        .req_data(req_data),
        .grant(grant),
        .ack(ack),
        .ok(ok),
        .busy(busy),
        .i2c_go(i2c_go),
        .i2c_addr(i2c_addr),
        .i2c_data(i2c_data),
        .i2c_done(i2c_done),
        .i2c_success(i2c_success)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc;
        @(negedge mclk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset;
        logic [26:0] all_out;
        do_reset();
        all_out = {grant, ack, ok, busy, i2c_go, i2c_addr, i2c_data};
        vectors++;
        if (all_out !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", all_out, 27'd0);
        end
    endtask

    task automatic test_single;
        req_addr[6:0] = 7'h50;
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        cyc();
        vectors++;
        if (grant !== 4'b0001) begin miscompares++; $display("FAIL single_grant: got %b expected %b", grant, 4'b0001); end
        vectors++;
        if ({busy, i2c_go} !== 2'b11) begin miscompares++; $display("FAIL single_busy_go: got %b expected %b", {busy, i2c_go}, 2'b11); end
        vectors++;
        if (i2c_addr !== 7'h50) begin miscompares++; $display("FAIL single_addr: got %h expected %h", i2c_addr, 7'h50); end
        vectors++;
        if (i2c_data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h expected %h", i2c_data, 8'hA5); end
        req = 4'b0000;
        repeat (3) cyc();
        vectors++;
        if ({i2c_go, ack, ok} !== 6'b1_0000_0) begin miscompares++; $display("FAIL single_wait: got %b expected %b", {i2c_go, ack, ok}, 6'b1_0000_0); end
        cyc();
        i2c_done = 1'b1;
        i2c_success = 1'b1;
        cyc();
        i2c_done = 1'b0;
        i2c_success = 1'b0;
        vectors++;
        if ({ack, ok} !== 5'b0001_1) begin miscompares++; $display("FAIL single_ack_ok: got %b expected %b", {ack, ok}, 5'b0001_1); end
        vectors++;
        if ({i2c_go, grant, busy} !== 6'b0_0001_1) begin miscompares++; $display("FAIL single_resp: got %b expected %b", {i2c_go, grant, busy}, 6'b0_0001_1); end
        cyc();
        vectors++;
        if ({grant, busy, ack, ok} !== 10'd0) begin miscompares++; $display("FAIL single_idle: got %b expected %b", {grant, busy, ack, ok}, 10'd0); end
    endtask

    task automatic test_round_robin;
        logic [3:0] order [5];
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0100;
        order[3] = 4'b1000;
        order[4] = 4'b0001;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            vectors++;
            if (grant !== order[i]) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, grant, order[i]); end
            cyc();
            i2c_done = 1'b1;
            i2c_success = 1'b1;
            cyc();
            i2c_done = 1'b0;
            i2c_success = 1'b0;
            vectors++;
            if ({ack, ok} !== {order[i], 1'b1}) begin miscompares++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, {ack, ok}, {order[i], 1'b1}); end
            cyc();
            vectors++;
            if ({grant, busy} !== 5'd0) begin miscompares++; $display("FAIL rr_gap[%0d]: got %b expected %b", i, {grant, busy}, 5'd0); end
            if (i == 4) req = 4'b0000;
        end
        cyc();
    endtask

    task automatic test_retry_exhaust;
        req = 4'b0010;
        cyc();
        req = 4'b0000;
        vectors++;
        if (grant !== 4'b0010) begin miscompares++; $display("FAIL nack_grant: got %b expected %b", grant, 4'b0010); end
        for (int p = 0; p < 3; p++) begin
            vectors++;
            if (i2c_go !== 1'b1) begin miscompares++; $display("FAIL nack_go_hi[%0d]: got %b expected %b", p, i2c_go, 1'b1); end
            cyc();
            i2c_done = 1'b1;
            i2c_success = 1'b0;
            cyc();
            i2c_done = 1'b0;
            if (p < 2) begin
                vectors++;
                if ({i2c_go, ack, busy} !== 6'b0_0000_1) begin miscompares++; $display("FAIL nack_gap[%0d]: got %b expected %b", p, {i2c_go, ack, busy}, 6'b0_0000_1); end
                cyc();
            end else begin
                vectors++;
                if ({ack, ok, i2c_go} !== 6'b0010_0_0) begin miscompares++; $display("FAIL nack_final: got %b expected %b", {ack, ok, i2c_go}, 6'b0010_0_0); end
            end
        end
        cyc();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL nack_idle: got %b expected %b", busy, 1'b0); end
    endtask

    task automatic test_nack_then_ack;
        req = 4'b0100;
        cyc();
        req = 4'b0000;
        vectors++;
        if (grant !== 4'b0100) begin miscompares++; $display("FAIL retry_grant: got %b expected %b", grant, 4'b0100); end
        cyc();
        i2c_done = 1'b1;
        i2c_success = 1'b0;
        cyc();
        i2c_done = 1'b0;
        vectors++;
        if (i2c_go !== 1'b0) begin miscompares++; $display("FAIL retry_gap_go: got %b expected %b", i2c_go, 1'b0); end
        cyc();
        vectors++;
        if (i2c_go !== 1'b1) begin miscompares++; $display("FAIL retry_relaunch: got %b expected %b", i2c_go, 1'b1); end
        cyc();
        i2c_done = 1'b1;
        i2c_success = 1'b1;
        cyc();
        i2c_done = 1'b0;
        i2c_success = 1'b0;
        vectors++;
        if ({ack, ok} !== 5'b0100_1) begin miscompares++; $display("FAIL retry_ack_ok: got %b expected %b", {ack, ok}, 5'b0100_1); end
        cyc();
    endtask

    task automatic test_timeout;
        req = 4'b1000;
        cyc();
        req = 4'b0000;
        vectors++;
        if (grant !== 4'b1000) begin miscompares++; $display("FAIL tmo_grant: got %b expected %b", grant, 4'b1000); end
        repeat (21) cyc();
        vectors++;
        if ({ack, i2c_go} !== 5'b0000_1) begin miscompares++; $display("FAIL tmo_early: got %b expected %b", {ack, i2c_go}, 5'b0000_1); end
        cyc();
        vectors++;
        if ({ack, ok, i2c_go} !== 6'b1000_0_0) begin miscompares++; $display("FAIL tmo_ack: got %b expected %b", {ack, ok, i2c_go}, 6'b1000_0_0); end
        cyc();
        vectors++;
        if ({i2c_go, busy, ack} !== 6'd0) begin miscompares++; $display("FAIL tmo_after: got %b expected %b", {i2c_go, busy, ack}, 6'd0); end
    endtask

    task automatic test_timeout_done_race;
        req = 4'b0001;
        cyc();
        req = 4'b0000;
        repeat (21) cyc();
        i2c_done = 1'b1;
        i2c_success = 1'b1;
        cyc();
        i2c_done = 1'b0;
        i2c_success = 1'b0;
        vectors++;
        if ({ack, ok} !== 5'b0001_1) begin miscompares++; $display("FAIL race_ack_ok: got %b expected %b", {ack, ok}, 5'b0001_1); end
        cyc();
    endtask

    task automatic test_operand_latch;
        req_addr[20:14] = 7'h2A;
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        cyc();
        req = 4'b0000;
        req_addr[20:14] = 7'h11;
        req_data[23:16] = 8'hFF;
        vectors++;
        if ({grant, i2c_addr, i2c_data} !== {4'b0100, 7'h2A, 8'h3C}) begin miscompares++; $display("FAIL latch_grant: got %h expected %h", {grant, i2c_addr, i2c_data}, {4'b0100, 7'h2A, 8'h3C}); end
        cyc();
        cyc();
        vectors++;
        if ({i2c_addr, i2c_data} !== {7'h2A, 8'h3C}) begin miscompares++; $display("FAIL latch_hold: got %h expected %h", {i2c_addr, i2c_data}, {7'h2A, 8'h3C}); end
        i2c_done = 1'b1;
        i2c_success = 1'b1;
        cyc();
        i2c_done = 1'b0;
        i2c_success = 1'b0;
        vectors++;
        if ({ack, ok} !== 5'b0100_1) begin miscompares++; $display("FAIL latch_ack: got %b expected %b", {ack, ok}, 5'b0100_1); end
        cyc();
        vectors++;
        if ({busy, i2c_data} !== {1'b0, 8'h3C}) begin miscompares++; $display("FAIL latch_idle_hold: got %h expected %h", {busy, i2c_data}, {1'b0, 8'h3C}); end
    endtask

    task automatic test_reset_mid;
        logic [26:0] all_out;
        req = 4'b0010;
        cyc();
        req = 4'b0000;
        vectors++;
        if (grant !== 4'b0010) begin miscompares++; $display("FAIL rstmid_grant: got %b expected %b", grant, 4'b0010); end
        cyc();
        cyc();
        rst = 1'b1;
        i2c_done = 1'b1;
        i2c_success = 1'b1;
        cyc();
        all_out = {grant, ack, ok, busy, i2c_go, i2c_addr, i2c_data};
        vectors++;
        if (all_out !== 27'd0) begin miscompares++; $display("FAIL rstmid_outputs: got %h expected %h", all_out, 27'd0); end
        rst = 1'b0;
        i2c_done = 1'b0;
        i2c_success = 1'b0;
        // clients 1 and 3 both request: a cleared ptr must choose client 1
        req = 4'b1010;
        cyc();
        req = 4'b0000;
        vectors++;
        if ({grant, ack} !== 8'b0010_0000) begin miscompares++; $display("FAIL rstmid_regrant: got %b expected %b", {grant, ack}, 8'b0010_0000); end
        cyc();
        i2c_done = 1'b1;
        i2c_success = 1'b1;
        cyc();
        i2c_done = 1'b0;
        i2c_success = 1'b0;
        vectors++;
        if ({ack, ok} !== 5'b0010_1) begin miscompares++; $display("FAIL rstmid_ack: got %b expected %b", {ack, ok}, 5'b0010_1); end
        cyc();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = '0;
        req_addr    = '0;
        req_data    = '0;
        i2c_done    = 1'b0;
        i2c_success = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_retry_exhaust();
        test_nack_then_ack();
        test_timeout();
        test_timeout_done_race();
        test_operand_latch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
